// File: rtl/registers_pkg.sv
// Shared CPU package: register-file default widths and the hard-wired zero register index.
package registers_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned ZERO_REG_IDX   = 0;

endpackage : registers_pkg

// File: rtl/registers.sv
// Register file: two combinational read ports, one synchronous write port,
// register 0 hard-wired to zero, synchronous active-low clear of all registers.
module registers
   import registers_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk_w_i,
   input  logic                  res_w_i_l,
   input  logic [ADDR_WIDTH-1:0] rd_reg_1_w_i,
   input  logic [ADDR_WIDTH-1:0] rd_reg_2_w_i,
   input  logic [ADDR_WIDTH-1:0] wr_reg_w_i,
   input  logic [DATA_WIDTH-1:0] wr_data_w_i,
   input  logic                  reg_wr_flag_w_i,
   output logic [DATA_WIDTH-1:0] rd_data_1_w_o,
   output logic [DATA_WIDTH-1:0] rd_data_2_w_o
);

   localparam int unsigned           REG_COUNT = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_REG  = ADDR_WIDTH'(ZERO_REG_IDX);

   // Register 0 has no storage; it is synthesized as a constant zero in the read muxes.
   logic [DATA_WIDTH-1:0] mem [1:REG_COUNT-1];

   logic wr_en;

   // Write decode: writes to the zero register are dropped.
   always_comb begin
      wr_en = 1'b0;
      if (reg_wr_flag_w_i && (wr_reg_w_i != ZERO_REG)) begin
         wr_en = 1'b1;
      end
   end

   // Storage update: clear has priority over a simultaneous write.
   always_ff @(posedge clk_w_i) begin
      if (!res_w_i_l) begin
         for (int i = 1; i < int'(REG_COUNT); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_reg_w_i] <= wr_data_w_i;
      end
   end

   // Read port 1: zero-latency mux, no write bypass.
   always_comb begin
      rd_data_1_w_o = '0;
      if (rd_reg_1_w_i != ZERO_REG) begin
         rd_data_1_w_o = mem[rd_reg_1_w_i];
      end
   end

   // Read port 2: independent copy of the port 1 mux.
   always_comb begin
      rd_data_2_w_o = '0;
      if (rd_reg_2_w_i != ZERO_REG) begin
         rd_data_2_w_o = mem[rd_reg_2_w_i];
      end
   end

endmodule : registers

// File: tb/tb_registers.sv
// Self-checking bench for the register file: directed cases then randomized
// traffic compared against an array reference model.
module tb_registers;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned NREG = 32;

   logic          clk = 1'b0;
   logic          res_l = 1'b0;
   logic [AW-1:0] rd1 = '0;
   logic [AW-1:0] rd2 = '0;
   logic [AW-1:0] wr_reg = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_flag = 1'b0;
   logic [DW-1:0] rdata1;
   logic [DW-1:0] rdata2;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model [NREG];

   registers #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk_w_i         (clk),
      .res_w_i_l       (res_l),
      .rd_reg_1_w_i    (rd1),
      .rd_reg_2_w_i    (rd2),
      .wr_reg_w_i      (wr_reg),
      .wr_data_w_i     (wr_data),
      .reg_wr_flag_w_i (wr_flag),
      .rd_data_1_w_o   (rdata1),
      .rd_data_2_w_o   (rdata2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] idx);
      return (idx == 0) ? '0 : model[idx];
   endfunction

   // Architectural effect of one rising edge on the reference model.
   task automatic model_edge(input logic r_l, input logic f, input logic [AW-1:0] w, input logic [DW-1:0] d);
      if (!r_l) begin
         for (int i = 0; i < int'(NREG); i++) model[i] = '0;
      end else if (f && w != 0) begin
         model[w] = d;
      end
   endtask

   // One cycle: drive on falling edge, check reads before and after the rising edge.
   task automatic cycle(input logic r_l, input logic f, input logic [AW-1:0] w,
                        input logic [DW-1:0] d, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input bit pre_check);
      @(negedge clk);
      res_l = r_l; wr_flag = f; wr_reg = w; wr_data = d; rd1 = a1; rd2 = a2;
      #1;
      if (pre_check) begin
         check("pre_rd1", rdata1, ref_read(a1));
         check("pre_rd2", rdata2, ref_read(a2));
      end
      @(posedge clk);
      model_edge(r_l, f, w, d);
      #1;
      check("post_rd1", rdata1, ref_read(a1));
      check("post_rd2", rdata2, ref_read(a2));
   endtask

   initial begin
      logic [AW-1:0] w, a1, a2;
      logic [DW-1:0] d;
      logic          f, r_l;

      // Reset for one edge, contents unknown before it.
      cycle(1'b0, 1'b1, AW'(9), 32'hFFFF_FFFF, AW'(9), AW'(0), 1'b0);
      for (int i = 0; i < int'(NREG); i++) begin
         cycle(1'b1, 1'b0, '0, '0, AW'(i), AW'(NREG - 1 - i), 1'b1);
         check("reset_zero", rdata1, 32'h0);
      end

      // Write 5, read back on both ports; neighbour stays zero.
      cycle(1'b1, 1'b1, AW'(5), 32'hDEAD_BEEF, AW'(5), AW'(4), 1'b1);
      cycle(1'b1, 1'b0, '0, '0, AW'(5), AW'(5), 1'b1);
      check("wr5_p1", rdata1, 32'hDEAD_BEEF);
      check("wr5_p2", rdata2, 32'hDEAD_BEEF);
      cycle(1'b1, 1'b0, '0, '0, AW'(6), AW'(0), 1'b1);
      check("other_zero", rdata1, 32'h0);

      // Zero register ignores writes.
      cycle(1'b1, 1'b1, AW'(0), 32'h1234_5678, AW'(0), AW'(0), 1'b1);
      check("zero_reg", rdata1, 32'h0);

      // Write disable.
      cycle(1'b1, 1'b0, AW'(7), 32'hCAFE_F00D, AW'(7), AW'(7), 1'b1);
      check("wr_dis", rdata2, 32'h0);

      // No bypass: old value before edge, new value after.
      cycle(1'b1, 1'b1, AW'(3), 32'h1111_1111, AW'(3), AW'(5), 1'b1);
      @(negedge clk);
      wr_flag = 1'b1; wr_reg = AW'(3); wr_data = 32'h2222_2222; rd1 = AW'(3); rd2 = AW'(3);
      #1;
      check("nobyp_pre", rdata1, 32'h1111_1111);
      @(posedge clk);
      model_edge(1'b1, 1'b1, AW'(3), 32'h2222_2222);
      #1;
      check("nobyp_post", rdata2, 32'h2222_2222);

      // Reset has priority over a write and only acts at the edge.
      cycle(1'b0, 1'b1, AW'(5), 32'hABCD_0123, AW'(5), AW'(3), 1'b1);
      check("rst_prio", rdata1, 32'h0);
      check("rst_clear", rdata2, 32'h0);

      // Random traffic: flag forced 0, forced 1, then random.
      for (int mode = 0; mode < 3; mode++) begin
         for (int n = 0; n < 10000; n++) begin
            w  = AW'($urandom_range(0, NREG - 1));
            a1 = AW'($urandom_range(0, NREG - 1));
            a2 = ($urandom_range(0, 7) == 0) ? a1 : AW'($urandom_range(0, NREG - 1));
            d  = DW'($urandom);
            f  = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            r_l = ($urandom_range(0, 999) != 0);
            cycle(r_l, f, w, d, a1, a2, 1'b1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_registers

// File: doc/registers.md
REGISTERS -- requirements
Module: registers

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register and data-port width.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width; register count = 2**ADDR_WIDTH (32).
REQ-003 clk_w_i  input  1  sole clock; all state updates on rising edge.
REQ-004 res_w_i_l  input  1  synchronous active-low reset, sampled on rising clk_w_i.
REQ-005 rd_reg_1_w_i  input  ADDR_WIDTH  read port 1 register index.
REQ-006 rd_reg_2_w_i  input  ADDR_WIDTH  read port 2 register index.
REQ-007 wr_reg_w_i  input  ADDR_WIDTH  write port register index.
REQ-008 wr_data_w_i  input  DATA_WIDTH  write data.
REQ-009 reg_wr_flag_w_i  input  1  write enable, active-high.
REQ-010 rd_data_1_w_o  output  DATA_WIDTH  contents of register rd_reg_1_w_i.
REQ-011 rd_data_2_w_o  output  DATA_WIDTH  contents of register rd_reg_2_w_i.

Function
REQ-012 The block SHALL hold 32 registers of DATA_WIDTH bits; register 0 SHALL always read 0.
REQ-013 Read ports SHALL be purely combinational: zero latency, outputs follow index and stored contents within the same cycle.
REQ-014 Both read ports SHALL be independent; identical indices SHALL return identical data.
REQ-015 On rising clk_w_i with res_w_i_l=1, reg_wr_flag_w_i=1 and wr_reg_w_i!=0, register wr_reg_w_i SHALL load wr_data_w_i.
REQ-016 Writes to index 0 SHALL be discarded; register 0 SHALL never hold a nonzero value.
REQ-017 With reg_wr_flag_w_i=0, no register SHALL change.
REQ-018 No write-to-read bypass: a read of the register being written SHALL show the old value until the rising edge, then the new value immediately after it.
REQ-019 Exactly one write per cycle; registers not addressed SHALL retain their values.
REQ-020 Inputs SHALL be treated as don't-care except at rising edges (write) and continuously for read indices; no handshake.

Reset
REQ-021 On rising clk_w_i with res_w_i_l=0, all 32 registers SHALL clear to 0.
REQ-022 Reset SHALL take priority over a simultaneous write; the write SHALL be dropped.
REQ-023 After the reset edge both read outputs SHALL be 0 for every index until a write occurs.
REQ-024 Reset asserted mid-operation SHALL take effect at the next rising edge only; before that edge contents and reads are unchanged.

Structure
REQ-025 DATA_WIDTH, ADDR_WIDTH defaults and the register-0 index constant SHALL live in the shared CPU package.
REQ-026 Implementation SHALL be a single flat module (storage array, write decode, two read muxes); no sub-module.

Verification
REQ-027 Reset: res_w_i_l=0 for one edge, then read all 32 indices on both ports -> all 0x00000000.
REQ-028 Write/read: write 0xDEADBEEF to reg 5 with flag=1, then rd_reg_1=5, rd_reg_2=5 -> both 0xDEADBEEF; reads of other regs 0.
REQ-029 Zero register: write 0x12345678 to reg 0 with flag=1 -> rd_data of reg 0 stays 0x00000000.
REQ-030 Write disable: flag=0, wr_reg=7, wr_data=0xCAFEF00D -> reg 7 unchanged (0 after reset).
REQ-031 No bypass: reg 3=0x11111111, write 0x22222222 to reg 3 while reading reg 3 -> 0x11111111 before edge, 0x22222222 after.
REQ-032 Random: 10,000 cycles each of flag=0, flag=1, random flag, random indices/data changed on falling edge, checked against a reference model at each rising edge -> 0 mismatches.
